// File: rtl/regfile_pkg.sv
// regfile_pkg: shared defaults and types for the integer register file with scoreboard.
package regfile_pkg;
  localparam int XLEN_DEF  = 32;
  localparam int NREGS_DEF = 32;
  typedef logic [4:0]  reg_addr_t;
  typedef logic [31:0] xdata_t;
endpackage

// File: rtl/regfile_rdport.sv
// regfile_rdport: one combinational read port with same-cycle write bypass and busy lookup.
module regfile_rdport import regfile_pkg::*; #(
  parameter int XLEN     = XLEN_DEF,
  parameter int NREGS    = NREGS_DEF,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 1,
  localparam int AW      = $clog2(NREGS)
) (
  input  logic [AW-1:0]               addr_i,
  input  logic [NREGS-1:0][XLEN-1:0]  mem_i,
  input  logic [NREGS-1:0]            pend_i,
  input  logic                        wr_en_i,
  input  logic [AW-1:0]               wr_addr_i,
  input  logic [XLEN-1:0]             wr_data_i,
  input  logic                        sb_set_en_i,
  input  logic [AW-1:0]               sb_set_addr_i,
  output logic [XLEN-1:0]             data_o,
  output logic                        busy_o
);
  logic zero_hit, byp_hit, set_hit, unused_taps;
  assign zero_hit    = (ZERO_REG != 0) && (addr_i == '0);
  assign byp_hit     = (BYPASS != 0) && wr_en_i && (wr_addr_i == addr_i);
  assign set_hit     = sb_set_en_i && (sb_set_addr_i == addr_i);
  // write-port taps are dead when bypass is compiled out
  assign unused_taps = ^{wr_data_i, set_hit};
  always_comb begin
    data_o = zero_hit ? '0 : byp_hit ? wr_data_i : mem_i[addr_i];
    busy_o = zero_hit ? 1'b0 : byp_hit ? set_hit : pend_i[addr_i];
  end
endmodule

// File: rtl/regfile_sb.sv
// regfile_sb: multi-read-port register file with per-register pending-write scoreboard.
module regfile_sb import regfile_pkg::*; #(
  parameter int XLEN     = XLEN_DEF,
  parameter int NREGS    = NREGS_DEF,
  parameter int NREAD    = 2,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 1,
  localparam int AW      = $clog2(NREGS)
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [NREAD*AW-1:0]    rd_addr,
  output logic [NREAD*XLEN-1:0]  rd_data,
  output logic [NREAD-1:0]       rd_busy,
  input  logic                   wr_en,
  input  logic [AW-1:0]          wr_addr,
  input  logic [XLEN-1:0]        wr_data,
  input  logic                   sb_set_en,
  input  logic [AW-1:0]          sb_set_addr,
  input  logic [AW-1:0]          dbg_addr,
  output logic [XLEN-1:0]        dbg_data,
  output logic [NREGS-1:0]       pending
);
  logic [NREGS-1:0][XLEN-1:0] mem_q, mem_d;
  logic [NREGS-1:0]           pend_q, pend_d;
  logic                       wr_ok, set_ok;
  assign wr_ok  = wr_en && !((ZERO_REG != 0) && (wr_addr == '0));
  assign set_ok = sb_set_en && !((ZERO_REG != 0) && (sb_set_addr == '0));
  // set is applied after the write so a colliding new producer keeps the bit
  always_comb begin
    mem_d  = mem_q;
    pend_d = pend_q;
    if (wr_ok) begin
      mem_d[wr_addr]  = wr_data;
      pend_d[wr_addr] = 1'b0;
    end
    if (set_ok) pend_d[sb_set_addr] = 1'b1;
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mem_q  <= '0;
      pend_q <= '0;
    end else begin
      mem_q  <= mem_d;
      pend_q <= pend_d;
    end
  end
  assign dbg_data = ((ZERO_REG != 0) && (dbg_addr == '0)) ? '0 : mem_q[dbg_addr];
  assign pending  = pend_q;
  for (genvar k = 0; k < NREAD; k++) begin : g_rd
    regfile_rdport #(
      .XLEN(XLEN), .NREGS(NREGS), .BYPASS(BYPASS), .ZERO_REG(ZERO_REG)
    ) u_port (
      .addr_i        (rd_addr[k*AW +: AW]),
      .mem_i         (mem_q),
      .pend_i        (pend_q),
      .wr_en_i       (wr_en),
      .wr_addr_i     (wr_addr),
      .wr_data_i     (wr_data),
      .sb_set_en_i   (sb_set_en),
      .sb_set_addr_i (sb_set_addr),
      .data_o        (rd_data[k*XLEN +: XLEN]),
      .busy_o        (rd_busy[k])
    );
  end
endmodule

// File: tb/tb_regfile_sb.sv
// tb_regfile_sb: directed vectors for bypassing, non-bypassing and 4-port/64-bit register files.
module tb_regfile_sb;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  logic [9:0]   a_rd_addr, b_rd_addr;
  logic [63:0]  a_rd_data, b_rd_data;
  logic [1:0]   a_rd_busy, b_rd_busy;
  logic         a_wr_en, b_wr_en, a_sb_set_en, b_sb_set_en;
  logic [4:0]   a_wr_addr, b_wr_addr, a_sb_set_addr, b_sb_set_addr, a_dbg_addr, b_dbg_addr;
  logic [31:0]  a_wr_data, b_wr_data, a_dbg_data, b_dbg_data, a_pending, b_pending;
  logic [15:0]  c_rd_addr;
  logic [255:0] c_rd_data;
  logic [3:0]   c_rd_busy, c_wr_addr, c_sb_set_addr, c_dbg_addr;
  logic         c_wr_en, c_sb_set_en;
  logic [63:0]  c_wr_data, c_dbg_data;
  logic [15:0]  c_pending;

  regfile_sb #(.BYPASS(1)) u_a (
    .clk(clk), .reset_n(reset_n), .rd_addr(a_rd_addr), .rd_data(a_rd_data), .rd_busy(a_rd_busy),
    .wr_en(a_wr_en), .wr_addr(a_wr_addr), .wr_data(a_wr_data), .sb_set_en(a_sb_set_en),
    .sb_set_addr(a_sb_set_addr), .dbg_addr(a_dbg_addr), .dbg_data(a_dbg_data), .pending(a_pending)
  );
  regfile_sb #(.BYPASS(0)) u_b (
    .clk(clk), .reset_n(reset_n), .rd_addr(b_rd_addr), .rd_data(b_rd_data), .rd_busy(b_rd_busy),
    .wr_en(b_wr_en), .wr_addr(b_wr_addr), .wr_data(b_wr_data), .sb_set_en(b_sb_set_en),
    .sb_set_addr(b_sb_set_addr), .dbg_addr(b_dbg_addr), .dbg_data(b_dbg_data), .pending(b_pending)
  );
  regfile_sb #(.XLEN(64), .NREGS(16), .NREAD(4)) u_c (
    .clk(clk), .reset_n(reset_n), .rd_addr(c_rd_addr), .rd_data(c_rd_data), .rd_busy(c_rd_busy),
    .wr_en(c_wr_en), .wr_addr(c_wr_addr), .wr_data(c_wr_data), .sb_set_en(c_sb_set_en),
    .sb_set_addr(c_sb_set_addr), .dbg_addr(c_dbg_addr), .dbg_data(c_dbg_data), .pending(c_pending)
  );

  typedef struct {
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic        se;
    logic [4:0]  sa;
    logic [4:0]  r0, r1;
    logic [31:0] d0, d1;
    logic [1:0]  busy;
    logic [31:0] pend;
    logic [31:0] dbg;
  } vec_t;

  vec_t tv [15];
  logic [63:0] cref [16];
  int nvec = 0;
  int nerr = 0;

  function automatic vec_t mk(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                              input logic se, input logic [4:0] sa, input logic [4:0] r0,
                              input logic [4:0] r1, input logic [31:0] d0, input logic [31:0] d1,
                              input logic [1:0] busy, input logic [31:0] pend, input logic [31:0] dbg);
    vec_t v;
    v.we = we; v.wa = wa; v.wd = wd; v.se = se; v.sa = sa; v.r0 = r0; v.r1 = r1;
    v.d0 = d0; v.d1 = d1; v.busy = busy; v.pend = pend; v.dbg = dbg;
    return v;
  endfunction

  task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", n, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    tv[0]  = mk(1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  5'd0,  5'd5,  32'h0,        32'h0,        2'b00, 32'h0,    32'h0);
    tv[1]  = mk(1'b1, 5'd5,  32'hDEADBEEF, 1'b0, 5'd0,  5'd5,  5'd5,  32'hDEADBEEF, 32'hDEADBEEF, 2'b00, 32'h0,    32'h0);
    tv[2]  = mk(1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  5'd5,  5'd0,  32'hDEADBEEF, 32'h0,        2'b00, 32'h0,    32'hDEADBEEF);
    tv[3]  = mk(1'b1, 5'd0,  32'h12345678, 1'b1, 5'd0,  5'd0,  5'd0,  32'h0,        32'h0,        2'b00, 32'h0,    32'h0);
    tv[4]  = mk(1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  5'd0,  5'd5,  32'h0,        32'hDEADBEEF, 2'b00, 32'h0,    32'h0);
    tv[5]  = mk(1'b0, 5'd0,  32'h0,        1'b1, 5'd9,  5'd9,  5'd9,  32'h0,        32'h0,        2'b00, 32'h0,    32'h0);
    tv[6]  = mk(1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  5'd9,  5'd5,  32'h0,        32'hDEADBEEF, 2'b01, 32'h200,  32'h0);
    tv[7]  = mk(1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  5'd5,  5'd9,  32'hDEADBEEF, 32'h0,        2'b10, 32'h200,  32'hDEADBEEF);
    tv[8]  = mk(1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  5'd9,  5'd9,  32'h0,        32'h0,        2'b11, 32'h200,  32'h0);
    tv[9]  = mk(1'b1, 5'd9,  32'h55,       1'b0, 5'd0,  5'd9,  5'd9,  32'h55,       32'h55,       2'b00, 32'h200,  32'h0);
    tv[10] = mk(1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  5'd9,  5'd9,  32'h55,       32'h55,       2'b00, 32'h0,    32'h55);
    tv[11] = mk(1'b1, 5'd12, 32'h77,       1'b1, 5'd12, 5'd12, 5'd12, 32'h77,       32'h77,       2'b11, 32'h0,    32'h0);
    tv[12] = mk(1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  5'd12, 5'd12, 32'h77,       32'h77,       2'b11, 32'h1000, 32'h77);
    tv[13] = mk(1'b1, 5'd12, 32'h88,       1'b0, 5'd0,  5'd12, 5'd9,  32'h88,       32'h55,       2'b00, 32'h1000, 32'h77);
    tv[14] = mk(1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  5'd12, 5'd12, 32'h88,       32'h88,       2'b00, 32'h0,    32'h88);
    for (int i = 0; i < 16; i++) cref[i] = 64'h0;
    {a_rd_addr, a_wr_en, a_wr_addr, a_wr_data, a_sb_set_en, a_sb_set_addr, a_dbg_addr} = '0;
    {b_rd_addr, b_wr_en, b_wr_addr, b_wr_data, b_sb_set_en, b_sb_set_addr, b_dbg_addr} = '0;
    {c_rd_addr, c_wr_en, c_wr_addr, c_wr_data, c_sb_set_en, c_sb_set_addr, c_dbg_addr} = '0;
    #1;
    chk("reset_a_pending", 64'(a_pending), 64'h0);
    chk("reset_b_pending", 64'(b_pending), 64'h0);
    chk("reset_c_busy", 64'(c_rd_busy), 64'h0);
    @(posedge clk);
    #1 reset_n = 1'b1;

    // instance A: bypass, zero register, scoreboard lifecycle, collision
    for (int i = 0; i < 15; i++) begin
      a_wr_en = tv[i].we; a_wr_addr = tv[i].wa; a_wr_data = tv[i].wd;
      a_sb_set_en = tv[i].se; a_sb_set_addr = tv[i].sa;
      a_rd_addr = {tv[i].r1, tv[i].r0}; a_dbg_addr = tv[i].r0;
      #3;
      chk($sformatf("v%0d_d0", i), 64'(a_rd_data[31:0]), 64'(tv[i].d0));
      chk($sformatf("v%0d_d1", i), 64'(a_rd_data[63:32]), 64'(tv[i].d1));
      chk($sformatf("v%0d_busy", i), 64'(a_rd_busy), 64'(tv[i].busy));
      chk($sformatf("v%0d_pend", i), 64'(a_pending), 64'(tv[i].pend));
      chk($sformatf("v%0d_dbg", i), 64'(a_dbg_data), 64'(tv[i].dbg));
      tick;
    end
    {a_wr_en, a_sb_set_en} = '0;

    // instance B: no bypass, write and clear are seen one cycle late
    b_wr_en = 1'b1; b_wr_addr = 5'd3; b_wr_data = 32'h11111111; b_rd_addr = {5'd3, 5'd3};
    #2 chk("nobyp_first", 64'(b_rd_data[63:32]), 64'h0);
    tick;
    b_wr_data = 32'hA5A5A5A5;
    #2 chk("nobyp_old", 64'(b_rd_data[63:32]), 64'h11111111);
    tick;
    b_wr_en = 1'b0;
    #2 chk("nobyp_new", 64'(b_rd_data[63:32]), 64'hA5A5A5A5);
    b_sb_set_en = 1'b1; b_sb_set_addr = 5'd3;
    tick;
    b_sb_set_en = 1'b0;
    #2 chk("nobyp_busy_set", 64'(b_rd_busy), 64'h3);
    b_wr_en = 1'b1; b_wr_data = 32'h5A5A5A5A;
    #1 chk("nobyp_busy_hold", 64'(b_rd_busy), 64'h3);
    tick;
    b_wr_en = 1'b0;
    #2 chk("nobyp_busy_clear", 64'(b_rd_busy), 64'h0);
    chk("nobyp_data", 64'(b_rd_data[31:0]), 64'h5A5A5A5A);

    // instance C: 4 ports, 64-bit, 16 registers against a reference array
    for (int i = 0; i < 32; i++) begin
      logic [3:0]  wa;
      logic [63:0] wd;
      wa = (i < 16) ? 4'(i) : 4'($urandom_range(0, 15));
      wd = {$urandom, $urandom};
      c_wr_en = 1'b1; c_wr_addr = wa; c_wr_data = wd;
      if (wa != 4'd0) cref[wa] = wd;
      tick;
    end
    c_wr_en = 1'b0;
    for (int i = 0; i < 16; i++) begin
      logic [3:0] ra [4];
      for (int k = 0; k < 4; k++) begin
        ra[k] = (i % 2 == 1) ? 4'(i) : 4'(i + 5 * k);
        c_rd_addr[k*4 +: 4] = ra[k];
      end
      #2;
      for (int k = 0; k < 4; k++)
        chk($sformatf("mp_i%0d_p%0d", i, k), c_rd_data[k*64 +: 64], cref[ra[k]]);
      chk($sformatf("mp_i%0d_busy", i), 64'(c_rd_busy), 64'h0);
      tick;
    end

    // instance A: asynchronous reset mid-cycle discards state and in-flight ops
    a_sb_set_en = 1'b1; a_sb_set_addr = 5'd7; a_rd_addr = {5'd5, 5'd7}; a_dbg_addr = 5'd5;
    tick;
    a_sb_set_en = 1'b0;
    #1;
    chk("pre_rst_busy", 64'(a_rd_busy), 64'h1);
    chk("pre_rst_pend", 64'(a_pending), 64'h80);
    chk("pre_rst_dbg", 64'(a_dbg_data), 64'hDEADBEEF);
    #1 reset_n = 1'b0;
    #1;
    chk("rst_dbg", 64'(a_dbg_data), 64'h0);
    chk("rst_pend", 64'(a_pending), 64'h0);
    chk("rst_busy", 64'(a_rd_busy), 64'h0);
    chk("rst_data", a_rd_data, 64'h0);
    a_wr_en = 1'b1; a_wr_addr = 5'd5; a_wr_data = 32'h11111111;
    a_sb_set_en = 1'b1; a_sb_set_addr = 5'd7;
    tick;
    {a_wr_en, a_sb_set_en} = '0;
    reset_n = 1'b1;
    #2;
    chk("rst_discard_dbg", 64'(a_dbg_data), 64'h0);
    chk("rst_discard_pend", 64'(a_pending), 64'h0);
    a_wr_en = 1'b1; a_wr_addr = 5'd6; a_wr_data = 32'hCAFEF00D; a_dbg_addr = 5'd6;
    a_rd_addr = {5'd0, 5'd6};
    tick;
    a_wr_en = 1'b0;
    #2;
    chk("post_rst_dbg", 64'(a_dbg_data), 64'hCAFEF00D);
    chk("post_rst_rd", 64'(a_rd_data[31:0]), 64'hCAFEF00D);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
